// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shares one UART transmitter between NUM_SRC requesters at packet
// granularity. A source raises src_hold to claim the transmitter for a whole
// packet. While it owns the transmitter it sends words with one-cycle src_req
// pulses. Ownership is handed over only after the owner drops src_hold and the
// UART has gone idle. An owner that holds but sends nothing for MAX_IDLE
// cycles is released by force. It then stays locked out until its src_hold
// has been seen low.
//
// Ports
//   clk          system clock, rising edge
//   n_reset      synchronous active-low reset
//   src_hold     per source: wants / keeps ownership for a packet
//   src_data     per source word, source i at [i*WORD_SIZE +: WORD_SIZE]
//   src_req      per source one-cycle word transmit request
//   src_ready    per source: a word offered now will be accepted
//   grant        one-hot current owner, zero when none
//   uart_ready   UART transmitter idle
//   uart_data    registered word to the UART
//   uart_req     registered one-cycle transmit strobe to the UART
//   wdog_err     sticky: an owner was forcibly released
//   fsm_state    current arbiter state (SM_IDLE=0, SM_OWN=1, SM_DRAIN=2)
//
// Handshake: a word moves from source i to the UART when src_req[i] and
// src_ready[i] are both high on a rising edge. src_ready is only high for the
// owner while the UART is idle and no strobe is already in flight. A src_req
// without src_ready is dropped, not queued. The forwarded word appears on
// uart_data with uart_req high for exactly the following cycle.
module uart_tx_arb #(
   parameter int WORD_SIZE = 8,
   parameter int NUM_SRC   = 2,
   parameter int MAX_IDLE  = 1023
) (
   input  logic                          clk,
   input  logic                          n_reset,
   input  logic [NUM_SRC-1:0]            src_hold,
   input  logic [NUM_SRC*WORD_SIZE-1:0]  src_data,
   input  logic [NUM_SRC-1:0]            src_req,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [NUM_SRC-1:0]            grant,
   input  logic                          uart_ready,
   output logic [WORD_SIZE-1:0]          uart_data,
   output logic                          uart_req,
   output logic                          wdog_err,
   output logic [1:0]                    fsm_state
);

   localparam int IDX_W = $clog2(NUM_SRC);
   localparam int CNT_W = $clog2(MAX_IDLE + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IDLE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRC - 1);

   typedef enum logic [1:0] {
      SM_IDLE  = 2'd0,
      SM_OWN   = 2'd1,
      SM_DRAIN = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [IDX_W-1:0]     owner, owner_next;
   logic [IDX_W-1:0]     rr_ptr, rr_next;
   logic [CNT_W-1:0]     wdog_cnt, cnt_next;
   logic [NUM_SRC-1:0]   block, block_next, block_set;
   logic [NUM_SRC-1:0]   grant_next;
   logic                 req_next;
   logic [WORD_SIZE-1:0] data_next;
   logic                 err_next;

   logic [NUM_SRC-1:0]   eligible;
   logic                 pick_found;
   logic [IDX_W-1:0]     pick_idx;
   logic [IDX_W-1:0]     cand;
   logic                 accept;
   logic [WORD_SIZE-1:0] owner_data;
   logic [WORD_SIZE-1:0] src_word [NUM_SRC];

   genvar g;
   for (g = 0; g < NUM_SRC; g++) begin : g_word
      assign src_word[g] = src_data[g*WORD_SIZE +: WORD_SIZE];
   end

   assign owner_data = src_word[owner];
   assign src_ready  = grant & {NUM_SRC{uart_ready & ~uart_req}};
   assign accept     = (state == SM_OWN) && ((src_req & src_ready) != '0);
   assign fsm_state  = state;

   // A source released by the watchdog stays out until it lets go of hold.
   assign eligible = src_hold & ~block;

   // Round-robin pick: first eligible source at or after rr_ptr, wrapping.
   always_comb begin
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = IDX_W'((int'(rr_ptr) + k) % NUM_SRC);
         if (!pick_found && eligible[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

   always_comb begin
      state_next = state;
      owner_next = owner;
      rr_next    = rr_ptr;
      cnt_next   = wdog_cnt;
      grant_next = grant;
      req_next   = 1'b0;
      data_next  = uart_data;
      err_next   = wdog_err;
      block_set  = '0;

      case (state)
         SM_IDLE: begin
            if (pick_found) begin
               state_next           = SM_OWN;
               owner_next           = pick_idx;
               grant_next           = '0;
               grant_next[pick_idx] = 1'b1;
               cnt_next             = '0;
            end
         end

         SM_OWN: begin
            if (accept) begin
               req_next  = 1'b1;
               data_next = owner_data;
               cnt_next  = '0;
            end else if (wdog_cnt != CNT_MAX) begin
               cnt_next = wdog_cnt + 1'b1;
            end
            // A normal release takes priority. A word accepted in the
            // release cycle is still forwarded above.
            if (!src_hold[owner]) begin
               state_next = SM_DRAIN;
            end else if (!accept && (cnt_next == CNT_MAX)) begin
               state_next       = SM_DRAIN;
               err_next         = 1'b1;
               block_set[owner] = 1'b1;
            end
         end

         SM_DRAIN: begin
            // Hand over only once the last strobe is out and the UART is idle.
            if (!uart_req && uart_ready) begin
               state_next = SM_IDLE;
               grant_next = '0;
               rr_next    = (owner == LAST_IDX) ? '0 : owner + 1'b1;
            end
         end

         default: begin
            state_next = SM_IDLE;
            grant_next = '0;
         end
      endcase

      block_next = (block & src_hold) | block_set;
   end

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= SM_IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         wdog_cnt  <= '0;
         block     <= '0;
         grant     <= '0;
         uart_req  <= 1'b0;
         uart_data <= '0;
         wdog_err  <= 1'b0;
      end else begin
         state     <= state_next;
         owner     <= owner_next;
         rr_ptr    <= rr_next;
         wdog_cnt  <= cnt_next;
         block     <= block_next;
         grant     <= grant_next;
         uart_req  <= req_next;
         uart_data <= data_next;
         wdog_err  <= err_next;
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb (WORD_SIZE=8, NUM_SRC=2, MAX_IDLE=15).
// Inputs are driven just after the falling edge. Registered outputs are
// sampled at the following falling edge. A transaction-level reference model
// tracks owner, drain, lockout and watchdog as plain integers.
// A small UART model stays busy for busy_len cycles after each strobe.
module tb_uart_tx_arb;
   localparam int MAXI = 15;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [1:0]  src_hold, src_req, src_ready, grant;
   logic [15:0] src_data;
   logic        uart_ready;
   logic [7:0]  uart_data;
   logic        uart_req, wdog_err;
   logic [1:0]  fsm_state;

   always #5 clk = ~clk;

   uart_tx_arb #(.WORD_SIZE(8), .NUM_SRC(2), .MAX_IDLE(MAXI)) dut (
      .clk(clk), .n_reset(n_reset), .src_hold(src_hold), .src_data(src_data),
      .src_req(src_req), .src_ready(src_ready), .grant(grant),
      .uart_ready(uart_ready), .uart_data(uart_data), .uart_req(uart_req),
      .wdog_err(wdog_err), .fsm_state(fsm_state));

   int checks = 0;
   int failures = 0;

   // reference model
   int       m_owner, m_pref, m_quiet;
   bit       m_drain, m_err, m_req;
   logic [7:0] m_data;
   bit [1:0] m_ban;
   int       busy, busy_len;
   logic [1:0] e_ready, obs_ready;
   logic [7:0] exp_q[$];

   function automatic bit bit_of(input logic [1:0] v, input int i);
      return (i == 0) ? v[0] : v[1];
   endfunction

   function automatic logic [7:0] word_of(input logic [15:0] v, input int i);
      return (i == 0) ? v[7:0] : v[15:8];
   endfunction

   function automatic logic [1:0] m_grant();
      if (m_owner < 0) return 2'b00;
      return (m_owner == 0) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] m_ready_fn(input logic ur);
      return (ur && !m_req) ? m_grant() : 2'b00;
   endfunction

   function automatic logic [1:0] m_phase();
      if (m_owner < 0) return 2'd0;
      return m_drain ? 2'd2 : 2'd1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_pref = 0; m_quiet = 0;
      m_drain = 0; m_err = 0; m_req = 0; m_data = 8'h00; m_ban = 2'b00;
      busy = 0;
   endtask

   task automatic model_step(input logic [1:0] h, input logic [1:0] r,
                             input logic [15:0] d, input logic ur);
      logic [1:0] rdy;
      int n_owner, n_pref, n_quiet;
      bit n_drain, n_req;
      logic [7:0] n_data;
      bit [1:0] ban_set;
      rdy = m_ready_fn(ur);
      n_owner = m_owner; n_pref = m_pref; n_quiet = m_quiet;
      n_drain = m_drain; n_req = 0; n_data = m_data; ban_set = 2'b00;
      if (m_owner < 0) begin
         for (int k = 0; k < 2; k++) begin
            int c;
            c = (m_pref + k) % 2;
            if (n_owner < 0 && bit_of(h, c) && !m_ban[c]) begin
               n_owner = c; n_drain = 0; n_quiet = 0;
            end
         end
      end else if (!m_drain) begin
         if (bit_of(r, m_owner) && bit_of(rdy, m_owner)) begin
            n_req = 1; n_data = word_of(d, m_owner); n_quiet = 0;
         end else if (m_quiet < MAXI) begin
            n_quiet = m_quiet + 1;
         end
         if (!bit_of(h, m_owner)) begin
            n_drain = 1;
         end else if (!n_req && n_quiet == MAXI) begin
            n_drain = 1; m_err = 1;
            ban_set = (m_owner == 0) ? 2'b01 : 2'b10;
         end
      end else if (!m_req && ur) begin
         n_pref = (m_owner + 1) % 2; n_owner = -1; n_drain = 0;
      end
      m_ban   = (m_ban & h) | ban_set;
      m_owner = n_owner; m_pref = n_pref; m_quiet = n_quiet;
      m_drain = n_drain; m_req = n_req; m_data = n_data;
   endtask

   // driver: one clock cycle with the given source inputs
   task automatic cycle(input logic [1:0] h, input logic [1:0] r, input logic [15:0] d);
      logic ur;
      ur = (busy == 0);
      src_hold = h; src_req = r; src_data = d; uart_ready = ur;
      e_ready = m_ready_fn(ur);
      #1;
      obs_ready = src_ready;
      @(negedge clk);
      model_step(h, r, d, ur);
      if (m_req) busy = busy_len;
      else if (busy > 0) busy--;
   endtask

   task automatic do_reset(input logic [1:0] h);
      n_reset = 1'b0; src_hold = h; src_req = 2'b00; src_data = 16'h0000; uart_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      n_reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset(2'b00);
      checks += 6;
      if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
      if (uart_req !== 1'b0) begin failures++; $display("FAIL reset_uart_req got=%b exp=0", uart_req); end
      if (uart_data !== 8'h00) begin failures++; $display("FAIL reset_uart_data got=%h exp=00", uart_data); end
      if (wdog_err !== 1'b0) begin failures++; $display("FAIL reset_wdog_err got=%b exp=0", wdog_err); end
      if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
      if (src_ready !== 2'b00) begin failures++; $display("FAIL reset_src_ready got=%b exp=00", src_ready); end
   endtask

   task automatic test_single_source();
      logic [7:0] words [3];
      logic [7:0] w;
      logic [1:0] rdy, r;
      logic [15:0] d;
      int sent, pulses;
      bit dropped;
      words[0] = 8'h41; words[1] = 8'h42; words[2] = 8'h43;
      do_reset(2'b00);
      busy_len = 10; sent = 0; pulses = 0; dropped = 0;
      exp_q.delete();
      for (int cyc = 0; cyc < 200; cyc++) begin
         rdy = m_ready_fn(busy == 0);
         r = 2'b00;
         d = {8'($urandom_range(0, 255)), 8'h00};
         if (sent == 3 && busy == 0 && !m_req) dropped = 1;
         if (!dropped && sent < 3 && rdy[0]) begin
            r = 2'b01; d[7:0] = words[sent];
            exp_q.push_back(words[sent]);
            sent++;
         end
         cycle(dropped ? 2'b00 : 2'b01, r, d);
         checks++;
         if (obs_ready !== e_ready) begin failures++; $display("FAIL single_src_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, e_ready); end
         if (uart_req === 1'b1) begin
            pulses++;
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL single_extra_word got=%h exp=none", uart_data);
            end else begin
               w = exp_q.pop_front();
               if (uart_data !== w) begin failures++; $display("FAIL single_word got=%h exp=%h", uart_data, w); end
            end
         end
         if (!dropped) begin
            checks++;
            if (grant !== 2'b01) begin failures++; $display("FAIL single_grant cyc=%0d got=%b exp=01", cyc, grant); end
         end
         if (dropped && m_owner < 0) break;
      end
      checks += 3;
      if (pulses != 3) begin failures++; $display("FAIL single_pulses got=%0d exp=3", pulses); end
      if (exp_q.size() != 0) begin failures++; $display("FAIL single_missing got=%0d exp=0", exp_q.size()); end
      if (grant !== 2'b00 || m_owner >= 0) begin failures++; $display("FAIL single_release got=%b exp=00", grant); end
   endtask

   task automatic test_contention();
      logic [1:0] rdy;
      bit sent, ok;
      do_reset(2'b00);
      busy_len = 2;
      cycle(2'b11, 2'b00, 16'h0000);
      checks++;
      if (grant !== 2'b01) begin failures++; $display("FAIL cont_first got=%b exp=01", grant); end
      sent = 0;
      for (int i = 0; i < 20 && !sent; i++) begin
         rdy = m_ready_fn(busy == 0);
         if (rdy[0]) begin cycle(2'b11, 2'b01, 16'h0033); sent = 1; end
         else cycle(2'b11, 2'b00, 16'h0000);
      end
      checks++;
      if (uart_req !== 1'b1 || uart_data !== 8'h33) begin failures++; $display("FAIL cont_word got=%b/%h exp=1/33", uart_req, uart_data); end
      cycle(2'b10, 2'b00, 16'h0000);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(2'b11, 2'b00, 16'h0000);
         checks++;
         if (grant !== m_grant()) begin failures++; $display("FAIL cont_wait got=%b exp=%b", grant, m_grant()); end
         if (m_owner == 1) begin ok = 1; break; end
      end
      checks++;
      if (!ok || grant !== 2'b10) begin failures++; $display("FAIL cont_second got=%b exp=10", grant); end
      cycle(2'b01, 2'b00, 16'h0000);
      ok = 0;
      for (int i = 0; i < 30; i++) begin
         cycle(2'b11, 2'b00, 16'h0000);
         if (m_owner == 0) begin ok = 1; break; end
      end
      checks++;
      if (!ok || grant !== 2'b01) begin failures++; $display("FAIL cont_third got=%b exp=01", grant); end
   endtask

   task automatic test_non_owner();
      do_reset(2'b00);
      busy_len = 0;
      cycle(2'b01, 2'b00, 16'h0000);
      cycle(2'b01, 2'b01, 16'h0041);
      checks++;
      if (uart_req !== 1'b1 || uart_data !== 8'h41) begin failures++; $display("FAIL nonown_first got=%b/%h exp=1/41", uart_req, uart_data); end
      // owner request while a strobe is in flight is dropped
      cycle(2'b01, 2'b01, 16'h0077);
      checks += 2;
      if (obs_ready !== 2'b00) begin failures++; $display("FAIL nonown_busy_ready got=%b exp=00", obs_ready); end
      if (uart_req !== 1'b0 || uart_data !== 8'h41) begin failures++; $display("FAIL nonown_busy_req got=%b/%h exp=0/41", uart_req, uart_data); end
      for (int i = 0; i < 5; i++) begin
         cycle(2'b01, 2'b10, 16'hFF00);
         checks += 3;
         if (obs_ready !== 2'b01) begin failures++; $display("FAIL nonown_ready got=%b exp=01", obs_ready); end
         if (uart_req !== 1'b0 || uart_data !== 8'h41) begin failures++; $display("FAIL nonown_out got=%b/%h exp=0/41", uart_req, uart_data); end
         if (grant !== 2'b01) begin failures++; $display("FAIL nonown_grant got=%b exp=01", grant); end
      end
   endtask

   task automatic test_hold_drop_req();
      int held;
      do_reset(2'b00);
      busy_len = 5;
      cycle(2'b01, 2'b00, 16'h0000);
      cycle(2'b00, 2'b01, 16'h005A);
      checks += 3;
      if (uart_req !== 1'b1 || uart_data !== 8'h5A) begin failures++; $display("FAIL drop_word got=%b/%h exp=1/5a", uart_req, uart_data); end
      if (fsm_state !== 2'd2) begin failures++; $display("FAIL drop_state got=%0d exp=2", fsm_state); end
      if (grant !== 2'b01) begin failures++; $display("FAIL drop_grant got=%b exp=01", grant); end
      held = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(2'b00, 2'b00, 16'h0000);
         if (grant === 2'b01) held++;
         else break;
      end
      checks += 2;
      if (held != 5) begin failures++; $display("FAIL drop_hold_cycles got=%0d exp=5", held); end
      if (grant !== 2'b00 || fsm_state !== 2'd0) begin failures++; $display("FAIL drop_release got=%b/%0d exp=00/0", grant, fsm_state); end
   endtask

   task automatic test_watchdog();
      int held;
      do_reset(2'b00);
      busy_len = 0;
      cycle(2'b01, 2'b00, 16'h0000);
      held = (grant === 2'b01) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         cycle(2'b11, 2'b00, 16'h0000);
         if (grant === 2'b01) held++;
         else break;
         if (held == 15) begin
            checks++;
            if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", wdog_err); end
         end
      end
      checks += 2;
      if (held != 16) begin failures++; $display("FAIL wdog_hold_cycles got=%0d exp=16", held); end
      if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_err got=%b exp=1", wdog_err); end
      cycle(2'b11, 2'b00, 16'h0000);
      checks++;
      if (grant !== 2'b10) begin failures++; $display("FAIL wdog_other got=%b exp=10", grant); end
      cycle(2'b01, 2'b00, 16'h0000);
      cycle(2'b01, 2'b00, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         cycle(2'b01, 2'b00, 16'h0000);
         checks++;
         if (grant !== 2'b00) begin failures++; $display("FAIL wdog_locked got=%b exp=00", grant); end
      end
      cycle(2'b00, 2'b00, 16'h0000);
      cycle(2'b01, 2'b00, 16'h0000);
      checks += 2;
      if (grant !== 2'b01) begin failures++; $display("FAIL wdog_regrant got=%b exp=01", grant); end
      if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
   endtask

   task automatic test_reset_mid();
      logic [1:0] rdy;
      bit sent;
      do_reset(2'b00);
      busy_len = 2;
      cycle(2'b01, 2'b00, 16'h0000);
      cycle(2'b00, 2'b00, 16'h0000);
      for (int i = 0; i < 10 && m_owner >= 0; i++) cycle(2'b00, 2'b00, 16'h0000);
      cycle(2'b10, 2'b00, 16'h0000);
      checks++;
      if (grant !== 2'b10) begin failures++; $display("FAIL mid_owner got=%b exp=10", grant); end
      sent = 0;
      for (int i = 0; i < 20 && !sent; i++) begin
         rdy = m_ready_fn(busy == 0);
         if (rdy[1]) begin cycle(2'b10, 2'b10, 16'hA100); sent = 1; end
         else cycle(2'b10, 2'b00, 16'h0000);
      end
      rdy = m_ready_fn(busy == 0);
      for (int i = 0; i < 20 && !rdy[1]; i++) begin
         cycle(2'b10, 2'b00, 16'h0000);
         rdy = m_ready_fn(busy == 0);
      end
      // second word requested in the same cycle reset is asserted
      src_hold = 2'b10; src_req = 2'b10; src_data = 16'hA200; uart_ready = 1'b1;
      n_reset = 1'b0;
      @(negedge clk);
      checks += 6;
      if (grant !== 2'b00) begin failures++; $display("FAIL mid_grant got=%b exp=00", grant); end
      if (uart_req !== 1'b0) begin failures++; $display("FAIL mid_uart_req got=%b exp=0", uart_req); end
      if (uart_data !== 8'h00) begin failures++; $display("FAIL mid_uart_data got=%h exp=00", uart_data); end
      if (wdog_err !== 1'b0) begin failures++; $display("FAIL mid_wdog got=%b exp=0", wdog_err); end
      if (src_ready !== 2'b00) begin failures++; $display("FAIL mid_src_ready got=%b exp=00", src_ready); end
      if (fsm_state !== 2'd0) begin failures++; $display("FAIL mid_state got=%0d exp=0", fsm_state); end
      model_reset();
      n_reset = 1'b1;
      cycle(2'b11, 2'b00, 16'h0000);
      checks++;
      if (grant !== 2'b01) begin failures++; $display("FAIL mid_after got=%b exp=01", grant); end
   endtask

   task automatic test_random();
      logic [1:0] h, r, rdy;
      bit lazy;
      do_reset(2'b00);
      h = 2'b00;
      for (int cyc = 0; cyc < 600; cyc++) begin
         lazy = ((cyc / 80) % 3) == 2;
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 9) == 0) h[i] = ~h[i];
         busy_len = $urandom_range(0, 3);
         rdy = m_ready_fn(busy == 0);
         r = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (!lazy && rdy[i] && $urandom_range(0, 2) == 0) r[i] = 1'b1;
            else if ($urandom_range(0, 9) == 0) r[i] = 1'b1;
         end
         cycle(h, r, 16'($urandom));
         checks += 6;
         if (obs_ready !== e_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, e_ready); end
         if (grant !== m_grant()) begin failures++; $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, grant, m_grant()); end
         if (uart_req !== m_req) begin failures++; $display("FAIL rand_uart_req cyc=%0d got=%b exp=%b", cyc, uart_req, m_req); end
         if (uart_data !== m_data) begin failures++; $display("FAIL rand_uart_data cyc=%0d got=%h exp=%h", cyc, uart_data, m_data); end
         if (wdog_err !== m_err) begin failures++; $display("FAIL rand_wdog cyc=%0d got=%b exp=%b", cyc, wdog_err, m_err); end
         if (fsm_state !== m_phase()) begin failures++; $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", cyc, fsm_state, m_phase()); end
      end
   endtask

   initial begin
      n_reset = 1'b0; src_hold = 2'b00; src_req = 2'b00; src_data = 16'h0000;
      uart_ready = 1'b1; busy_len = 0;
      e_ready = 2'b00; obs_ready = 2'b00;
      model_reset();
      test_reset();
      test_single_source();
      test_contention();
      test_non_owner();
      test_hold_drop_req();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter WORD_SIZE, default 8: width of one UART word.
REQ-002 Parameter NUM_SRC, default 2, legal 2..4: number of requesters sharing the UART transmitter.
REQ-003 Parameter MAX_IDLE, default 1023: owner watchdog limit in cycles.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 n_reset  input  1  reset, synchronous, active-low.
REQ-006 src_hold  input  NUM_SRC  per source: high while the source wants, or keeps, ownership for a whole packet.
REQ-007 src_data  input  NUM_SRC*WORD_SIZE  per-source word; source i occupies bits [i*WORD_SIZE +: WORD_SIZE].
REQ-008 src_req  input  NUM_SRC  per-source one-cycle word transmit request.
REQ-009 src_ready  output  NUM_SRC  per-source "UART may accept a word".
REQ-010 grant  output  NUM_SRC  one-hot current owner; all zero when none.
REQ-011 uart_ready  input  1  UART transmitter idle.
REQ-012 uart_data  output  WORD_SIZE  registered word to UART.
REQ-013 uart_req  output  1  registered one-cycle transmit strobe to UART.
REQ-014 wdog_err  output  1  sticky: an owner was forcibly released.

Function
REQ-015 States SHALL be SM_IDLE, SM_OWN, SM_DRAIN.
REQ-016 SM_IDLE: if any src_hold is high, grant SHALL go to the first holder at or after rr_ptr, wrapping modulo NUM_SRC; grant SHALL register next cycle; state SHALL become SM_OWN.
REQ-017 SM_IDLE with no src_hold high: state and grant SHALL hold; grant SHALL be all zero.
REQ-018 src_ready[i] SHALL equal grant[i] AND uart_ready AND NOT uart_req; non-owners SHALL see 0.
REQ-019 In SM_OWN, owner src_req with src_ready high SHALL cause uart_data = owner's src_data and uart_req = 1 on the next cycle; uart_req SHALL be high for exactly one cycle per accepted word.
REQ-020 src_req when the corresponding src_ready is low, or from a non-owner, SHALL be ignored; uart_data SHALL hold.
REQ-021 Owner src_hold low in SM_OWN SHALL move to SM_DRAIN; a word requested in that same cycle SHALL still be forwarded.
REQ-022 SM_DRAIN: when uart_req = 0 and uart_ready = 1, grant SHALL clear, rr_ptr SHALL become (owner + 1) mod NUM_SRC, and state SHALL become SM_IDLE.
REQ-023 Arbitration SHALL be packet-granular; ownership SHALL never change inside SM_OWN except by watchdog.
REQ-024 A watchdog counter SHALL clear on each accepted owner word and on entry to SM_OWN, and increment each SM_OWN cycle otherwise, saturating.
REQ-025 On reaching MAX_IDLE the block SHALL enter SM_DRAIN and set wdog_err, which stays high until reset.
REQ-026 A source SHALL not be re-granted while its src_hold stays continuously high after a watchdog release; it SHALL be eligible once src_hold has been seen low.
REQ-027 Minimum gap between two SM_IDLE grants SHALL be 3 cycles.

Reset
REQ-028 Under n_reset low: state = SM_IDLE, grant = 0, src_ready = 0, uart_req = 0, uart_data = 0, rr_ptr = 0, watchdog = 0, wdog_err = 0, block masks cleared.
REQ-029 Reset asserted mid-packet SHALL abort immediately with no further uart_req; the next grant after reset SHALL follow rr_ptr = 0.

Verification
REQ-030 Single source: src_hold[0] = 1, three words 0x41/0x42/0x43 each sent when src_ready[0] is high, UART model busy 10 cycles per word -> exactly three uart_req pulses, data in order, grant = 01 throughout, then 00 after hold drops.
REQ-031 Contention: src_hold = 11 on the same cycle from reset -> source 0 is granted first; source 1 is granted only after source 0 releases and drains; the next contention favours source 1.
REQ-032 Non-owner src_req[1] = 1 with data 0xFF while source 0 owns -> no uart_req, uart_data unchanged.
REQ-033 Hold drop and src_req in the same cycle -> word forwarded, SM_DRAIN, grant cleared after uart_ready returns.
REQ-034 Owner holds, no requests, MAX_IDLE = 15 -> forced release after 15 cycles, wdog_err = 1, other holder granted, stalled source not re-granted until its hold toggles.
REQ-035 n_reset low during the second word of a packet -> all outputs 0 the next cycle; after release, the holder at index 0 wins first.
